// File: rtl/controller_responder.sv
// Controller-side emulation of the LATCH/PULSE/DATA gamepad link: a 4021-style
// parallel-in/serial-out register fed from a live button vector.

module cr_in_filter #(
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level
);
  logic       sync1_q, sync2_q, filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  // The count runs only while the synchronised level disagrees with the filtered one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = 4'd0;
    if (sync2_q != filt_q) begin
      if (cnt_q == 4'(FILTER_CYCLES - 1)) filt_d = sync2_q;
      else                                cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = filt_q;
endmodule

module controller_responder #(
  parameter int   FILTER_CYCLES = 2,
  parameter logic FILL_VALUE    = 1'b1
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic [7:0] I_BUTTONS,
  input  logic       I_LATCH,
  input  logic       I_PULSE,
  output logic       O_DATA,
  output logic       O_FRAME_DONE,
  output logic       O_BUSY
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       data_q, data_d, fd_q, fd_d, busy_q, busy_d;
  logic       lat_lvl, pul_lvl, lat_prev_q, pul_prev_q;
  logic       lat_rise, lat_fall, pul_rise;
  logic [7:0] load_val;

  cr_in_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_lat_filt (
    .clk(I_CLK), .rst(I_RESET), .async_in(I_LATCH), .level(lat_lvl));
  cr_in_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_pul_filt (
    .clk(I_CLK), .rst(I_RESET), .async_in(I_PULSE), .level(pul_lvl));

  assign lat_rise = lat_lvl & ~lat_prev_q;
  assign lat_fall = ~lat_lvl & lat_prev_q;
  assign pul_rise = pul_lvl & ~pul_prev_q;

  // Wire order A,B,SELECT,START,UP,DOWN,LEFT,RIGHT from sr[0] upward, active-low.
  assign load_val = ~{I_BUTTONS[0], I_BUTTONS[1], I_BUTTONS[3], I_BUTTONS[2],
                      I_BUTTONS[7], I_BUTTONS[6], I_BUTTONS[5], I_BUTTONS[4]};

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q    <= IDLE;
      sr_q       <= 8'hFF;
      cnt_q      <= 4'd0;
      data_q     <= 1'b1;
      fd_q       <= 1'b0;
      busy_q     <= 1'b0;
      lat_prev_q <= 1'b0;
      pul_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      fd_q       <= fd_d;
      busy_q     <= busy_d;
      lat_prev_q <= lat_lvl;
      pul_prev_q <= pul_lvl;
    end
  end

  // LATCH events take priority over PULSE in SHIFT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lat_lvl) state_d = LOAD;
      LOAD:    if (lat_fall) state_d = SHIFT;
      SHIFT: begin
        if (lat_rise)                          state_d = LOAD;
        else if (pul_rise && cnt_q == 4'd7)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    fd_d  = 1'b0;
    if (state_d == LOAD) begin
      sr_d  = load_val;
      cnt_d = 4'd0;
    end else if (state_q == SHIFT && pul_rise) begin
      sr_d  = {FILL_VALUE, sr_q[7:1]};
      cnt_d = (cnt_q == 4'd8) ? 4'd8 : cnt_q + 4'd1;
      fd_d  = (cnt_q == 4'd7);
    end
    data_d = (state_d == IDLE) ? FILL_VALUE : sr_d[0];
    busy_d = (state_d != IDLE);
  end

  assign O_DATA       = data_q;
  assign O_FRAME_DONE = fd_q;
  assign O_BUSY       = busy_q;
endmodule
